// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flag positions, FP CSR addresses and ops.
package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4,
        RM_DYN = 3'd7
    } rm_e;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // operand must already be masked to the field width of the addressed CSR
    function automatic logic [7:0] csr_update(input logic [1:0] op,
                                              input logic [7:0] old_val,
                                              input logic [7:0] operand);
        logic [7:0] res;
        res = old_val;
        case (csr_op_e'(op))
            CSR_RW:  res = operand;
            CSR_RS:  res = old_val | operand;
            CSR_RC:  res = old_val & ~operand;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fpu_rm_resolve.sv
// Resolves an instruction rm field (static or DYN) against frm into the rounding mode to use.
// Latency: purely combinational. Backpressure: none.
// Reserved encodings (5, 6, or DYN selecting frm 5..7) flag rm_illegal and drive RNE.
module fpu_rm_resolve
    import fpu_pkg::*;
(
    input  logic [2:0] instr_rm,
    input  logic [2:0] frm,
    output logic [2:0] rm_out,
    output logic       rm_illegal
);

    always_comb begin
        rm_out     = 3'b000;
        rm_illegal = 1'b0;
        case (instr_rm)
            RM_RNE, RM_RTZ, RM_RDN, RM_RUP, RM_RMM: rm_out = instr_rm;
            RM_DYN: begin
                if (frm <= RM_RMM) begin
                    rm_out = frm;
                end else begin
                    rm_illegal = 1'b1;
                end
            end
            default: rm_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_csr.sv
// FPU control/status registers (frm, sticky fflags) with CSR access and rounding-mode resolution.
// Latency: CSR response one cycle after the request (read-before-write); rm resolution combinational.
// Backpressure: none, one CSR request accepted every cycle.
module fpu_csr
    import fpu_pkg::*;
#(
    parameter logic [2:0] RESET_FRM = 3'b000,
    parameter int         ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_valid,
    input  logic [1:0]        csr_op,
    input  logic [ADDR_W-1:0] csr_addr,
    input  logic [31:0]       csr_wdata,
    output logic              csr_rvalid,
    output logic [31:0]       csr_rdata,
    output logic              csr_illegal,
    input  logic [2:0]        instr_rm,
    output logic [2:0]        rm_out,
    output logic              rm_illegal,
    input  logic              flag_valid,
    input  logic [4:0]        flag_in,
    output logic [4:0]        fflags_out,
    output logic [2:0]        frm_out
);

    logic [2:0]  frm_q, frm_nxt;
    logic [4:0]  fflags_q, fflags_nxt;
    logic        rvalid_q, illegal_q;
    logic [31:0] rdata_q;

    logic        hit_fflags, hit_frm, hit_fcsr, known;
    logic [7:0]  old_val, mask, new_val;
    logic        unused_wdata;

    assign unused_wdata = ^csr_wdata[31:8];

    always_comb begin
        hit_fflags = (csr_addr == ADDR_W'(CSR_FFLAGS));
        hit_frm    = (csr_addr == ADDR_W'(CSR_FRM));
        hit_fcsr   = (csr_addr == ADDR_W'(CSR_FCSR));
        known      = hit_fflags | hit_frm | hit_fcsr;

        old_val = 8'h00;
        mask    = 8'h00;
        if (hit_fflags) begin
            old_val = {3'b000, fflags_q};
            mask    = 8'h1F;
        end else if (hit_frm) begin
            old_val = {5'b00000, frm_q};
            mask    = 8'h07;
        end else if (hit_fcsr) begin
            old_val = {frm_q, fflags_q};
            mask    = 8'hFF;
        end
        new_val = csr_update(csr_op, old_val, csr_wdata[7:0] & mask);

        frm_nxt    = frm_q;
        fflags_nxt = fflags_q;
        if (csr_valid) begin
            if (hit_fflags) fflags_nxt = new_val[4:0];
            if (hit_frm)    frm_nxt    = new_val[2:0];
            if (hit_fcsr)   {frm_nxt, fflags_nxt} = new_val;
        end
        // the retiring op is ordered after the CSR instruction, so its flags land on top
        if (flag_valid) fflags_nxt = fflags_nxt | flag_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_q     <= RESET_FRM;
            fflags_q  <= 5'b00000;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            frm_q     <= frm_nxt;
            fflags_q  <= fflags_nxt;
            rvalid_q  <= csr_valid;
            rdata_q   <= csr_valid ? {24'h0, old_val} : 32'h0;
            illegal_q <= csr_valid & ~known;
        end
    end

    assign csr_rvalid  = rvalid_q;
    assign csr_rdata   = rdata_q;
    assign csr_illegal = illegal_q;
    assign fflags_out  = fflags_q;
    assign frm_out     = frm_q;

    fpu_rm_resolve u_rm_resolve (
        .instr_rm   (instr_rm),
        .frm        (frm_q),
        .rm_out     (rm_out),
        .rm_illegal (rm_illegal)
    );

endmodule

// File: tb/tb_fpu_csr.sv
// Bench for fpu_csr: directed vector table, a reset-during-access sequence, then random traffic vs a model.
module tb_fpu_csr;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rvalid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [2:0]  instr_rm;
    logic [2:0]  rm_out;
    logic        rm_illegal;
    logic        flag_valid;
    logic [4:0]  flag_in;
    logic [4:0]  fflags_out;
    logic [2:0]  frm_out;

    always #5 clk = ~clk;

    fpu_csr #(.RESET_FRM(3'b000), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rvalid(csr_rvalid), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .instr_rm(instr_rm), .rm_out(rm_out), .rm_illegal(rm_illegal),
        .flag_valid(flag_valid), .flag_in(flag_in),
        .fflags_out(fflags_out), .frm_out(frm_out)
    );

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        fv;
        logic [4:0]  fin;
        logic [2:0]  rm;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_ill;
        logic [4:0]  e_ff;
        logic [2:0]  e_frm;
        logic [2:0]  e_rmo;
        logic        e_rmi;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // rm checked during the cycle, registered outputs checked just after the edge
    task automatic run_vec(input vec_t t, input logic r, input string tag);
        @(negedge clk);
        rst = r; csr_valid = t.v; csr_op = t.op; csr_addr = t.addr; csr_wdata = t.wdata;
        flag_valid = t.fv; flag_in = t.fin; instr_rm = t.rm;
        #1;
        chk({tag, ".rm_out"}, {29'h0, rm_out}, {29'h0, t.e_rmo});
        chk({tag, ".rm_illegal"}, {31'h0, rm_illegal}, {31'h0, t.e_rmi});
        @(posedge clk);
        #1;
        chk({tag, ".rvalid"}, {31'h0, csr_rvalid}, {31'h0, t.e_rvalid});
        chk({tag, ".rdata"}, csr_rdata, t.e_rdata);
        chk({tag, ".illegal"}, {31'h0, csr_illegal}, {31'h0, t.e_ill});
        chk({tag, ".fflags"}, {27'h0, fflags_out}, {27'h0, t.e_ff});
        chk({tag, ".frm"}, {29'h0, frm_out}, {29'h0, t.e_frm});
    endtask

    // reference state
    int m_frm, m_ff;

    function automatic vec_t model_step(input vec_t t);
        vec_t o;
        int   old_v, width_mask, opnd, nv;
        bit   legal;
        o = t;
        if (t.rm <= 4)      begin o.e_rmo = t.rm; o.e_rmi = 1'b0; end
        else if (t.rm == 7) begin
            if (m_frm <= 4) begin o.e_rmo = 3'(m_frm); o.e_rmi = 1'b0; end
            else            begin o.e_rmo = 3'd0;      o.e_rmi = 1'b1; end
        end else            begin o.e_rmo = 3'd0;      o.e_rmi = 1'b1; end

        legal = 1'b1; old_v = 0; width_mask = 0;
        case (t.addr)
            12'h001: begin old_v = m_ff;              width_mask = 'h1F; end
            12'h002: begin old_v = m_frm;             width_mask = 'h07; end
            12'h003: begin old_v = m_frm * 32 + m_ff; width_mask = 'hFF; end
            default: legal = 1'b0;
        endcase
        opnd = int'(t.wdata) & width_mask;
        nv = old_v;
        if (t.op == 2'b01) nv = opnd;
        if (t.op == 2'b10) nv = old_v | opnd;
        if (t.op == 2'b11) nv = old_v & ~opnd & width_mask;

        o.e_rvalid = t.v;
        o.e_rdata  = (t.v && legal) ? 32'(old_v) : 32'h0;
        o.e_ill    = t.v && !legal;
        if (t.v && legal) begin
            if (t.addr == 12'h001) m_ff = nv;
            if (t.addr == 12'h002) m_frm = nv;
            if (t.addr == 12'h003) begin m_frm = nv / 32; m_ff = nv % 32; end
        end
        if (t.fv) m_ff = m_ff | int'(t.fin);
        o.e_ff  = 5'(m_ff);
        o.e_frm = 3'(m_frm);
        return o;
    endfunction

    vec_t tbl[16];
    vec_t rv;

    initial begin
        //            v  op     addr     wdata         fv  fin       rm    rval rdata   ill  ff        frm   rmo   rmi
        tbl[0]  = '{1, 2'b00, 12'h003, 32'h0,        0, 5'b00000, 3'd0, 1, 32'h00, 0, 5'h00, 3'd0, 3'd0, 0};
        tbl[1]  = '{1, 2'b01, 12'h002, 32'h3,        0, 5'b00000, 3'd7, 1, 32'h00, 0, 5'h00, 3'd3, 3'd0, 0};
        tbl[2]  = '{0, 2'b00, 12'h000, 32'h0,        0, 5'b00000, 3'd7, 0, 32'h00, 0, 5'h00, 3'd3, 3'd3, 0};
        tbl[3]  = '{0, 2'b00, 12'h000, 32'h0,        1, 5'b00001, 3'd1, 0, 32'h00, 0, 5'h01, 3'd3, 3'd1, 0};
        tbl[4]  = '{0, 2'b00, 12'h000, 32'h0,        1, 5'b10000, 3'd3, 0, 32'h00, 0, 5'h11, 3'd3, 3'd3, 0};
        tbl[5]  = '{1, 2'b00, 12'h001, 32'h0,        0, 5'b00000, 3'd4, 1, 32'h11, 0, 5'h11, 3'd3, 3'd4, 0};
        tbl[6]  = '{1, 2'b11, 12'h001, 32'h1F,       1, 5'b00100, 3'd6, 1, 32'h11, 0, 5'h04, 3'd3, 3'd0, 1};
        tbl[7]  = '{1, 2'b01, 12'h003, 32'hFFFFFFE5, 0, 5'b00000, 3'd2, 1, 32'h64, 0, 5'h05, 3'd7, 3'd2, 0};
        tbl[8]  = '{1, 2'b00, 12'h002, 32'h0,        0, 5'b00000, 3'd7, 1, 32'h07, 0, 5'h05, 3'd7, 3'd0, 1};
        tbl[9]  = '{0, 2'b00, 12'h000, 32'h0,        0, 5'b00000, 3'd5, 0, 32'h00, 0, 5'h05, 3'd7, 3'd0, 1};
        tbl[10] = '{1, 2'b00, 12'h7C0, 32'h0,        0, 5'b00000, 3'd0, 1, 32'h00, 1, 5'h05, 3'd7, 3'd0, 0};
        tbl[11] = '{1, 2'b10, 12'h001, 32'h0,        0, 5'b00000, 3'd7, 1, 32'h05, 0, 5'h05, 3'd7, 3'd0, 1};
        tbl[12] = '{1, 2'b11, 12'h002, 32'h4,        0, 5'b00000, 3'd0, 1, 32'h07, 0, 5'h05, 3'd3, 3'd0, 0};
        tbl[13] = '{1, 2'b10, 12'h003, 32'h18,       0, 5'b00000, 3'd7, 1, 32'h65, 0, 5'h1D, 3'd3, 3'd3, 0};
        tbl[14] = '{1, 2'b01, 12'h001, 32'hFFFFFF0A, 1, 5'b10000, 3'd1, 1, 32'h1D, 0, 5'h1A, 3'd3, 3'd1, 0};
        tbl[15] = '{1, 2'b00, 12'h3C0, 32'h0,        0, 5'b00000, 3'd7, 1, 32'h00, 1, 5'h1A, 3'd3, 3'd3, 0};

        rst = 1'b1; csr_valid = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        flag_valid = 1'b0; flag_in = 5'b0; instr_rm = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rvalid", {31'h0, csr_rvalid}, 32'h0);
        chk("reset.rdata", csr_rdata, 32'h0);
        chk("reset.illegal", {31'h0, csr_illegal}, 32'h0);
        chk("reset.fflags", {27'h0, fflags_out}, 32'h0);
        chk("reset.frm", {29'h0, frm_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // reset on top of an frm write: write is dropped and no response follows
        run_vec('{1, 2'b01, 12'h002, 32'h5, 1, 5'b11111, 3'd7, 0, 32'h0, 0, 5'h00, 3'd0, 3'd3, 0},
                1'b1, "rst_mid");
        run_vec('{0, 2'b00, 12'h000, 32'h0, 0, 5'b00000, 3'd7, 0, 32'h0, 0, 5'h00, 3'd0, 3'd0, 0},
                1'b0, "post_rst");

        m_frm = 0; m_ff = 0;
        for (int i = 0; i < 400; i++) begin
            rv.v     = ($urandom_range(0, 3) != 0);
            rv.op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       rv.addr = 12'h001;
                1:       rv.addr = 12'h002;
                2:       rv.addr = 12'h003;
                3:       rv.addr = 12'h000;
                default: rv.addr = 12'($urandom_range(4, 4095));
            endcase
            rv.wdata = $urandom;
            if ($urandom_range(0, 7) == 0) rv.wdata = 32'h0;
            rv.fv    = ($urandom_range(0, 2) == 0);
            rv.fin   = 5'($urandom_range(0, 31));
            rv.rm    = 3'($urandom_range(0, 7));
            rv = model_step(rv);
            run_vec(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
